// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler: single-request DRAM command sequencer with a 16-bank open-row table
module bank_cmd_scheduler #(
  parameter int INDEX_BITS = 7,
  parameter int RA_BITS = 16,
  parameter int CA_BITS = 10,
  parameter int DATA_BITS = 16,
  parameter int T_RCD = 4,
  parameter int T_RP = 4,
  parameter int T_CCD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_type,
  input  logic [1:0]            req_bg,
  input  logic [1:0]            req_ba,
  input  logic [RA_BITS-1:0]    req_row,
  input  logic [CA_BITS-1:0]    req_col,
  input  logic [DATA_BITS-1:0]  req_data,
  input  logic [INDEX_BITS-1:0] req_idx,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_code,
  output logic [1:0]            cmd_bg,
  output logic [1:0]            cmd_ba,
  output logic [RA_BITS-1:0]    cmd_row,
  output logic [CA_BITS-1:0]    cmd_col,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx,
  output logic                  busy
);
  localparam int WW = $clog2((T_RCD > T_RP ? T_RCD : T_RP) + 1);
  localparam int CW = $clog2(T_CCD + 1);
  localparam logic [WW-1:0] RP_LD = WW'(T_RP > 1 ? T_RP - 2 : 0);
  localparam logic [WW-1:0] RCD_LD = WW'(T_RCD > 1 ? T_RCD - 2 : 0);
  typedef enum logic [2:0] {IDLE, DECODE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS} state_t;
  state_t state, state_nx;
  logic typ_q;
  logic [3:0] bank_q;
  logic [RA_BITS-1:0] row_q;
  logic [CA_BITS-1:0] col_q;
  logic [DATA_BITS-1:0] data_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [15:0] open_q;
  logic [RA_BITS-1:0] row_tab [16];
  logic [WW-1:0] wait_q;
  logic [CW-1:0] ccd_q;
  logic issue_cas;
  assign req_ready = (state == IDLE) & ~rst;
  assign busy = state != IDLE;
  assign issue_cas = (state == CAS) && (ccd_q == '0);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = req_valid ? DECODE : IDLE;
      DECODE:   state_nx = !open_q[bank_q] ? ACT : (row_tab[bank_q] == row_q) ? CAS : PRE;
      PRE:      state_nx = (T_RP > 1) ? WAIT_RP : ACT;
      WAIT_RP:  state_nx = (wait_q == '0) ? ACT : WAIT_RP;
      ACT:      state_nx = (T_RCD > 1) ? WAIT_RCD : CAS;
      WAIT_RCD: state_nx = (wait_q == '0) ? CAS : WAIT_RCD;
      CAS:      state_nx = issue_cas ? IDLE : CAS;
      default:  state_nx = IDLE;
    endcase
  end
  // Outputs come only from state and latched request fields, so nothing from req_* reaches cmd_*.
  always_comb begin
    cmd_code = (state == ACT) ? 3'd1 : (state == PRE) ? 3'd4 : issue_cas ? (typ_q ? 3'd3 : 3'd2) : 3'd0;
    cmd_valid = cmd_code != 3'd0;
    cmd_bg = cmd_valid ? bank_q[3:2] : 2'd0;
    cmd_ba = cmd_valid ? bank_q[1:0] : 2'd0;
    cmd_idx = cmd_valid ? idx_q : '0;
    cmd_row = (state == ACT) ? row_q : '0;
    cmd_col = issue_cas ? col_q : '0;
    cmd_data = (issue_cas && typ_q) ? data_q : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      typ_q <= 1'b0;
      bank_q <= '0;
      row_q <= '0;
      col_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      open_q <= '0;
      wait_q <= '0;
      ccd_q <= '0;
      for (int i = 0; i < 16; i++) row_tab[i] <= '0;
    end else begin
      state <= state_nx;
      if (req_valid && req_ready) begin
        typ_q <= req_type;
        bank_q <= {req_bg, req_ba};
        row_q <= req_row;
        col_q <= req_col;
        data_q <= req_data;
        idx_q <= req_idx;
      end
      if (state == PRE) open_q[bank_q] <= 1'b0;
      if (state == ACT) begin
        open_q[bank_q] <= 1'b1;
        row_tab[bank_q] <= row_q;
      end
      // Wait states run for T-1 cycles so the next command lands exactly T cycles later.
      wait_q <= (state == PRE) ? RP_LD : (state == ACT) ? RCD_LD : (wait_q != '0) ? wait_q - 1'b1 : wait_q;
      ccd_q <= issue_cas ? CW'(T_CCD - 1) : (ccd_q != '0) ? ccd_q - 1'b1 : ccd_q;
    end
  end
endmodule

// File: doc/bank_cmd_scheduler.md
BANK_CMD_SCHEDULER -- requirements
Module: bank_cmd_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
  INDEX_BITS, 7, request index width
  RA_BITS, 16, row address width
  CA_BITS, 10, column address width
  DATA_BITS, 16, write data width
  T_RCD, 4, minimum cycles from ACT to RD/WR on same bank (>=1)
  T_RP, 4, minimum cycles from PRE to ACT on same bank (>=1)
  T_CCD, 2, minimum cycles between consecutive RD/WR commands (>=1)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  req_valid  in  1  request from the arbiter is present
  req_ready  out  1  scheduler accepts the request this cycle
  req_type  in  1  0 = read, 1 = write
  req_bg  in  2  bank group
  req_ba  in  2  bank
  req_row  in  RA_BITS  row
  req_col  in  CA_BITS  column
  req_data  in  DATA_BITS  write data
  req_idx  in  INDEX_BITS  request index
  cmd_valid  out  1  command issued this cycle (one-cycle pulse)
  cmd_code  out  3  1 = ACT, 2 = RD, 3 = WR, 4 = PRE, 0 = NOP
  cmd_bg, cmd_ba  out  2 each  target bank
  cmd_row  out  RA_BITS  row (meaningful for ACT)
  cmd_col  out  CA_BITS  column (meaningful for RD/WR)
  cmd_data  out  DATA_BITS  write data (meaningful for WR)
  cmd_idx  out  INDEX_BITS  index of the request being served
  busy  out  1  a request is in flight (state != IDLE)

Function
REQ-003 The block SHALL keep a 16-entry open-row table indexed by {bg,ba}: one open bit plus RA_BITS row per bank.
REQ-004 States SHALL be IDLE, DECODE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS.
REQ-005 req_ready SHALL equal (state == IDLE); a handshake (req_valid & req_ready) SHALL latch all req_* fields and move to DECODE.
REQ-006 DECODE SHALL last exactly one cycle: bank open with equal row -> CAS; bank closed -> ACT; bank open with different row -> PRE.
REQ-007 PRE SHALL issue cmd PRE for one cycle, clear the bank's open bit, then go to WAIT_RP so that ACT issues exactly T_RP cycles after PRE (T_RP = 1 goes directly to ACT).
REQ-008 ACT SHALL issue cmd ACT with the latched row for one cycle, set open bit and row, then wait so that CAS is entered exactly T_RCD cycles after ACT.
REQ-009 CAS SHALL issue RD (type 0) or WR (type 1) only when the global CCD counter is 0, holding in CAS with cmd_valid = 0 otherwise; on issue it SHALL load the counter with T_CCD-1 and return to IDLE.
REQ-010 The CCD counter SHALL decrement by 1 per cycle and saturate at 0; it SHALL be a $clog2(T_CCD+1)-bit register.
REQ-011 All cmd_* outputs SHALL be driven from state and latched registers only (no combinational path from req_* inputs); cmd_code SHALL be 0 and cmd_valid 0 in every cycle without an issue.
REQ-012 Command latency from handshake cycle c: row hit -> RD/WR at c+2; closed bank -> ACT at c+2, RD/WR at c+2+T_RCD; row conflict -> PRE at c+2, ACT at c+2+T_RP, RD/WR at c+2+T_RP+T_RCD (each subject to REQ-009 stall).
REQ-013 Rows SHALL be left open after RD/WR (open-page policy); no auto-precharge.
REQ-014 req_valid while busy SHALL be ignored; the arbiter holds it until req_ready.

Reset
REQ-015 While rst is high: state = IDLE, all open bits = 0, CCD counter = 0, req_ready = 0, busy = 0, cmd_valid = 0, all other cmd_* = 0.
REQ-016 rst asserted mid-sequence SHALL abort the in-flight request immediately without issuing further commands; req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-017 After reset, read bg=1 ba=2 row=0x0010 col=5 -> ACT row 0x0010 at c+2, RD col 5 at c+6, req_ready back to 1 at c+7.
REQ-018 Second read same bank, row 0x0010 col 9 -> RD at c+2, no ACT/PRE.
REQ-019 Write same bank, row 0x0020 -> PRE at c+2, ACT row 0x0020 at c+6, WR with req_data at c+10, table row = 0x0020.
REQ-020 Two back-to-back hits with T_CCD = 4 -> second RD stalls in CAS until 4 cycles after the first RD.
REQ-021 rst pulsed during WAIT_RCD -> no RD issued, all outputs per REQ-015, next request to that bank issues ACT (table cleared).
